// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: default widths, FSM encoding and
// small helpers used by the stage top and its memory-interface FSM.
package mem_stage_pkg;

  localparam int WIDTH_D_DEF     = 32;
  localparam int ADDR_RFILE_DEF  = 5;
  localparam int ADDR_DMEM_DEF   = 10;
  localparam int TIMEOUT_CYC_DEF = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dmem_st_e;

  // Word accesses only: any nonzero byte offset is misaligned.
  function automatic logic is_misal(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_dmem_if_fsm.sv
// Data-memory handshake FSM: request/stall generation, timeout counting and
// the registered one-cycle error pulse.
module dmem_if_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_acc,
  input  logic i_bad,
  input  logic i_ack,
  output logic o_req,
  output logic o_stall,
  output logic o_tmo,
  output logic o_err
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

  dmem_st_e      r_st;
  logic [CW-1:0] r_cnt;
  logic          w_tmo;

  // An ack arriving on the last allowed cycle still completes the access.
  assign w_tmo = (r_st == ST_WAIT) && (r_cnt == TMO) && !i_ack;
  assign o_tmo = w_tmo;

  always_comb begin
    o_req   = 1'b0;
    o_stall = 1'b0;
    case (r_st)
      ST_IDLE: begin
        o_req   = i_acc;
        o_stall = i_acc & ~i_ack;
      end
      ST_WAIT: begin
        o_req   = ~w_tmo;
        o_stall = ~i_ack & ~w_tmo;
      end
      default: begin
        o_req   = 1'b0;
        o_stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st  <= ST_IDLE;
      r_cnt <= '0;
      o_err <= 1'b0;
    end else begin
      o_err <= i_bad | w_tmo;
      case (r_st)
        ST_IDLE: begin
          if (i_acc && !i_ack) begin
            r_st  <= ST_WAIT;
            r_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (i_ack || w_tmo) r_st <= ST_IDLE;
          else                r_cnt <= r_cnt + CW'(1);
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: turns EX/MEM controls into a data-memory transaction,
// stalls upstream while memory is busy, and holds the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH_D     = WIDTH_D_DEF,
  parameter int ADDR_RFILE  = ADDR_RFILE_DEF,
  parameter int ADDR_DMEM   = ADDR_DMEM_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_to_rfile_t2,
  input  logic                  rfile_w_t2,
  input  logic                  mem_r_t2,
  input  logic                  mem_w_t2,
  input  logic [WIDTH_D-1:0]    y_t,
  input  logic [WIDTH_D-1:0]    rb_data_wab_t2,
  input  logic [ADDR_RFILE-1:0] wb_addr_t,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_DMEM-1:0]  dmem_addr,
  output logic [WIDTH_D-1:0]    dmem_wdata,
  input  logic [WIDTH_D-1:0]    dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  mem_stall,
  output logic                  mem_err,
  output logic                  rfile_w_t3,
  output logic [ADDR_RFILE-1:0] wb_addr_t2,
  output logic [WIDTH_D-1:0]    wb_data
);

  logic w_access, w_illegal, w_misal, w_bad, w_legal, w_tmo, w_err;

  assign w_access  = mem_r_t2 | mem_w_t2;
  assign w_illegal = mem_r_t2 & mem_w_t2;
  assign w_misal   = w_access & is_misal(y_t[1:0]);
  assign w_bad     = w_illegal | w_misal;
  assign w_legal   = w_access & ~w_bad;

  // Bus fields come straight from the frozen EX/MEM register, so they stay
  // stable for the whole WAIT period without extra capture flops.
  assign dmem_we    = mem_w_t2;
  assign dmem_addr  = y_t[ADDR_DMEM+1:2];
  assign dmem_wdata = rb_data_wab_t2;

  dmem_if_fsm #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_acc   (w_legal),
    .i_bad   (w_bad),
    .i_ack   (dmem_ack),
    .o_req   (dmem_req),
    .o_stall (mem_stall),
    .o_tmo   (w_tmo),
    .o_err   (mem_err)
  );

  assign w_err = w_bad | w_tmo;

  // Stalled cycles insert a bubble; address and data keep their last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rfile_w_t3 <= 1'b0;
      wb_addr_t2 <= '0;
      wb_data    <= '0;
    end else if (mem_stall) begin
      rfile_w_t3 <= 1'b0;
    end else begin
      rfile_w_t3 <= rfile_w_t2 & ~w_err;
      wb_addr_t2 <= wb_addr_t;
      wb_data    <= mem_to_rfile_t2 ? dmem_rdata : y_t;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB contents are queued when
// each cycle's stimulus is applied and compared after the following edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_to_rfile_t2, rfile_w_t2, mem_r_t2, mem_w_t2;
  logic [31:0] y_t, rb_data_wab_t2, dmem_rdata;
  logic [4:0]  wb_addr_t;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall, mem_err, rfile_w_t3;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata, wb_data;
  logic [4:0]  wb_addr_t2;

  mem_stage #(
    .WIDTH_D(32), .ADDR_RFILE(5), .ADDR_DMEM(10), .TIMEOUT_CYC(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_to_rfile_t2(mem_to_rfile_t2), .rfile_w_t2(rfile_w_t2),
    .mem_r_t2(mem_r_t2), .mem_w_t2(mem_w_t2),
    .y_t(y_t), .rb_data_wab_t2(rb_data_wab_t2), .wb_addr_t(wb_addr_t),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .mem_err(mem_err),
    .rfile_w_t3(rfile_w_t3), .wb_addr_t2(wb_addr_t2), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rfw;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        err;
  } wb_t;

  wb_t         sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          bus_chk = 1'b0;
  logic [9:0]  x_addr;
  logic        x_we;
  logic [31:0] x_wdata;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mr, input logic mw, input logic sel, input logic rfw,
                       input logic [31:0] y, input logic [31:0] wd, input logic [4:0] wba,
                       input logic [31:0] rd, input logic ack);
    mem_r_t2 = mr; mem_w_t2 = mw; mem_to_rfile_t2 = sel; rfile_w_t2 = rfw;
    y_t = y; rb_data_wab_t2 = wd; wb_addr_t = wba; dmem_rdata = rd; dmem_ack = ack;
  endtask

  // One clock: combinational outputs mid-cycle, registered outputs after the edge.
  task automatic cyc(input logic ereq, input logic estall, input logic erfw,
                     input logic [4:0] ewba, input logic [31:0] ewbd, input logic eerr);
    wb_t e;
    @(negedge clk);
    chk("dmem_req", dmem_req, ereq);
    chk("mem_stall", mem_stall, estall);
    if (bus_chk) begin
      chk("dmem_addr", dmem_addr, x_addr);
      chk("dmem_we", dmem_we, x_we);
      chk("dmem_wdata", dmem_wdata, x_wdata);
    end
    sb_q.push_back(wb_t'({erfw, ewba, ewbd, eerr}));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("rfile_w_t3", rfile_w_t3, e.rfw);
    chk("wb_addr_t2", wb_addr_t2, e.wba);
    chk("wb_data", wb_data, e.wbd);
    chk("mem_err", mem_err, e.err);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rfw", rfile_w_t3, 1'b0);
    chk("rst_wba", wb_addr_t2, 5'd0);
    chk("rst_wbd", wb_data, 32'h0);
    chk("rst_err", mem_err, 1'b0);
    rst_n = 1'b1;

    // ALU op: one-cycle write-back, no memory traffic
    drive(0, 0, 0, 1, 32'h55, 32'h0, 5'd3, 32'h0, 0);
    cyc(0, 0, 1, 5'd3, 32'h55, 0);

    // Load acked in the same cycle
    drive(1, 0, 1, 1, 32'h40, 32'h0, 5'd5, 32'hCAFE, 1);
    bus_chk = 1'b1; x_addr = 10'h10; x_we = 1'b0; x_wdata = 32'h0;
    cyc(1, 0, 1, 5'd5, 32'hCAFE, 0);

    // Store acked after three stalled cycles; rfw=1 store writes y_t
    drive(0, 1, 0, 1, 32'h84, 32'hDEADBEEF, 5'd7, 32'h1111, 0);
    x_addr = 10'h21; x_we = 1'b1; x_wdata = 32'hDEADBEEF;
    repeat (3) cyc(1, 1, 0, 5'd5, 32'hCAFE, 0);
    dmem_ack = 1'b1;
    cyc(1, 0, 1, 5'd7, 32'h84, 0);
    bus_chk = 1'b0;

    // Misaligned load: no request, error pulse, write suppressed
    drive(1, 0, 1, 1, 32'h42, 32'h0, 5'd9, 32'h1234, 0);
    cyc(0, 0, 0, 5'd9, 32'h1234, 1);

    // ALU op with a stray ack: ignored, error pulse ends
    drive(0, 0, 0, 1, 32'h77, 32'h0, 5'd4, 32'h0, 1);
    cyc(0, 0, 1, 5'd4, 32'h77, 0);

    // Illegal load+store
    drive(1, 1, 0, 1, 32'h48, 32'h5, 5'd6, 32'h0, 0);
    cyc(0, 0, 0, 5'd6, 32'h48, 1);

    // Never acked: 16 stalled cycles, then abort
    drive(1, 0, 0, 1, 32'h100, 32'h0, 5'd2, 32'hBAD, 0);
    repeat (16) cyc(1, 1, 0, 5'd6, 32'h48, 0);
    cyc(0, 0, 0, 5'd2, 32'h100, 1);

    // Back in IDLE: an immediately acked load does not stall
    drive(1, 0, 1, 1, 32'h8, 32'h0, 5'd1, 32'hF00D, 1);
    cyc(1, 0, 1, 5'd1, 32'hF00D, 0);

    // Reset in the middle of WAIT
    drive(1, 0, 1, 1, 32'hC, 32'h0, 5'd8, 32'h9, 0);
    repeat (3) cyc(1, 1, 0, 5'd1, 32'hF00D, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 0);
    @(negedge clk);
    chk("rstw_req", dmem_req, 1'b0);
    chk("rstw_stall", mem_stall, 1'b0);
    chk("rstw_rfw", rfile_w_t3, 1'b0);
    chk("rstw_wba", wb_addr_t2, 5'd0);
    chk("rstw_wbd", wb_data, 32'h0);
    chk("rstw_err", mem_err, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(0, 0, 0, 1, 32'hAB, 32'h0, 5'd10, 32'h0, 0);
    cyc(0, 0, 1, 5'd10, 32'hAB, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
